// File: rtl/prim_pad_filter_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prim_pad_filter_bank : per-pad synchronizer, glitch filter, edge detect and
//                        registered output driver with virtual open-drain.
// Revision 1.0
// ---------------------------------------------------------------------------
module prim_pad_filter_bank #(
   parameter int NumPads    = 8,
   parameter int SyncStages = 2,
   parameter int CntWidth   = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumPads-1:0]  pad_in_i,
   input  logic [NumPads-1:0]  ie_i,
   input  logic [NumPads-1:0]  invert_i,
   input  logic [NumPads-1:0]  filter_en_i,
   input  logic [CntWidth-1:0] filter_thresh_i,
   input  logic [NumPads-1:0]  out_i,
   input  logic [NumPads-1:0]  oe_i,
   input  logic [NumPads-1:0]  virt_od_en_i,
   output logic [NumPads-1:0]  pad_out_o,
   output logic [NumPads-1:0]  pad_oe_o,
   output logic [NumPads-1:0]  in_o,
   output logic [NumPads-1:0]  rise_o,
   output logic [NumPads-1:0]  fall_o
);

   logic [SyncStages-1:0][NumPads-1:0] sync_q, sync_d;
   logic [NumPads-1:0]                 sync_inv;
   logic [NumPads-1:0]                 filt_q, filt_d;
   logic [NumPads-1:0]                 filt_dly_q, filt_dly_d;
   logic [NumPads-1:0][CntWidth-1:0]   cnt_q, cnt_d;
   logic [NumPads-1:0]                 out_inv;
   logic [NumPads-1:0]                 pad_out_q, pad_out_d;
   logic [NumPads-1:0]                 pad_oe_q, pad_oe_d;

   // Gating with ie_i before the first flop keeps disabled pads at a clean 0.
   always_comb begin
      sync_d = {sync_q[SyncStages-2:0], pad_in_i & ie_i};
   end

   // The filter lives in the inverted domain, so an invert_i change is just
   // another mismatch that must survive the threshold like a pad transition.
   assign sync_inv = sync_q[SyncStages-1] ^ invert_i;

   always_comb begin
      filt_d     = filt_q;
      cnt_d      = cnt_q;
      filt_dly_d = filt_q;
      for (int i = 0; i < NumPads; i++) begin
         if (!filter_en_i[i]) begin
            filt_d[i] = sync_inv[i];
            cnt_d[i]  = '0;
         end else if (sync_inv[i] == filt_q[i]) begin
            cnt_d[i]  = '0;
         end else if (cnt_q[i] >= filter_thresh_i) begin
            filt_d[i] = sync_inv[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i]  = cnt_q[i] + CntWidth'(1);
         end
      end
   end

   // Open-drain emulation: a logical high releases the driver instead of driving it.
   assign out_inv = out_i ^ invert_i;

   always_comb begin
      pad_out_d = out_inv;
      pad_oe_d  = oe_i & ~(out_inv & virt_od_en_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q     <= '0;
         filt_q     <= '0;
         filt_dly_q <= '0;
         cnt_q      <= '0;
         pad_out_q  <= '0;
         pad_oe_q   <= '0;
      end else begin
         sync_q     <= sync_d;
         filt_q     <= filt_d;
         filt_dly_q <= filt_dly_d;
         cnt_q      <= cnt_d;
         pad_out_q  <= pad_out_d;
         pad_oe_q   <= pad_oe_d;
      end
   end

   assign in_o      = filt_q;
   assign rise_o    = filt_q & ~filt_dly_q;
   assign fall_o    = ~filt_q & filt_dly_q;
   assign pad_out_o = pad_out_q;
   assign pad_oe_o  = pad_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_prim_pad_filter_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prim_pad_filter_bank : directed-vector bench for prim_pad_filter_bank.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_prim_pad_filter_bank;

   localparam int NP = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NP-1:0] pad_in, ie, invert, filter_en, out_d, oe, virt_od;
   logic [CW-1:0] thresh;
   logic [NP-1:0] pad_out, pad_oe, in_o, rise, fall;

   int n_checks = 0;
   int n_pass   = 0;
   logic seen_in, seen_rise;

   prim_pad_filter_bank #(
      .NumPads    (NP),
      .SyncStages (2),
      .CntWidth   (CW)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .pad_in_i        (pad_in),
      .ie_i            (ie),
      .invert_i        (invert),
      .filter_en_i     (filter_en),
      .filter_thresh_i (thresh),
      .out_i           (out_d),
      .oe_i            (oe),
      .virt_od_en_i    (virt_od),
      .pad_out_o       (pad_out),
      .pad_oe_o        (pad_oe),
      .in_o            (in_o),
      .rise_o          (rise),
      .fall_o          (fall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      pad_in    = '0;
      ie        = '0;
      invert    = '0;
      filter_en = '0;
      thresh    = '0;
      out_d     = 8'hFF;
      oe        = 8'hFF;
      virt_od   = '0;
      tick(2);
      check("rst_in",      32'(in_o),    32'h0);
      check("rst_rise",    32'(rise),    32'h0);
      check("rst_fall",    32'(fall),    32'h0);
      check("rst_pad_out", 32'(pad_out), 32'h0);
      check("rst_pad_oe",  32'(pad_oe),  32'h0);
      out_d = '0;
      oe    = '0;

      // Bypass latency on pad 0: visible 3 edges after the change.
      rst_n = 1'b1;
      ie    = 8'hFF;
      tick(4);
      pad_in[0] = 1'b1;
      tick(2);
      check("byp_c2_in",   32'(in_o[0]), 32'h0);
      tick(1);
      check("byp_c3_in",   32'(in_o[0]), 32'h1);
      check("byp_c3_rise", 32'(rise),    32'h01);
      tick(1);
      check("byp_c4_rise", 32'(rise),    32'h0);
      check("byp_c4_in",   32'(in_o[0]), 32'h1);
      pad_in[0] = 1'b0;
      tick(2);
      check("byp_fall_c2", 32'(fall[0]), 32'h0);
      tick(1);
      check("byp_fall_c3", 32'(fall),    32'h01);
      tick(1);
      check("byp_fall_c4", 32'(fall),    32'h0);
      tick(4);

      // Glitch rejection on pad 1 with T=3.
      filter_en = 8'h02;
      thresh    = 4'd3;
      pad_in[1] = 1'b1;
      tick(3);
      pad_in[1] = 1'b0;
      seen_in   = 1'b0;
      seen_rise = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         seen_in   = seen_in | in_o[1];
         seen_rise = seen_rise | rise[1];
      end
      check("glitch_in",   32'(seen_in),   32'h0);
      check("glitch_rise", 32'(seen_rise), 32'h0);
      pad_in[1] = 1'b1;
      tick(5);
      check("filt_c5_in",  32'(in_o[1]), 32'h0);
      tick(1);
      check("filt_c6_in",  32'(in_o[1]), 32'h1);
      check("filt_c6_rise", 32'(rise),   32'h02);
      pad_in[1] = 1'b0;
      tick(5);
      check("filt_fall_c5", 32'(in_o[1]), 32'h1);
      tick(1);
      check("filt_fall_c6", 32'(fall),    32'h02);
      tick(4);

      // Threshold lowered mid-count on pad 2: T=8, c=5, then T=2.
      filter_en = 8'h06;
      thresh    = 4'd8;
      pad_in[2] = 1'b1;
      tick(7);
      check("thr_c7_in",   32'(in_o[2]), 32'h0);
      thresh = 4'd2;
      tick(1);
      check("thr_c8_in",   32'(in_o[2]), 32'h1);
      check("thr_c8_rise", 32'(rise),    32'h04);
      pad_in[2] = 1'b0;
      tick(4);
      check("thr_fall_c4", 32'(in_o[2]), 32'h1);
      tick(1);
      check("thr_fall_c5", 32'(in_o[2]), 32'h0);
      tick(4);

      // Reset mid-count on pad 4 (T=5, c=3) while bypass pad 5 sits high.
      pad_in[5] = 1'b1;
      tick(5);
      check("pre_rst_in5", 32'(in_o), 32'h20);
      filter_en = 8'h16;
      thresh    = 4'd5;
      pad_in[4] = 1'b1;
      tick(5);
      rst_n = 1'b0;
      tick(1);
      check("midrst_in",   32'(in_o), 32'h0);
      check("midrst_rise", 32'(rise), 32'h0);
      check("midrst_fall", 32'(fall), 32'h0);
      rst_n = 1'b1;
      tick(3);
      check("postrst_c3_in",   32'(in_o), 32'h20);
      check("postrst_c3_rise", 32'(rise), 32'h20);
      tick(4);
      check("postrst_c7_in4",  32'(in_o[4]), 32'h0);
      tick(1);
      check("postrst_c8_in4",  32'(in_o[4]), 32'h1);
      check("postrst_c8_rise", 32'(rise),    32'h10);
      pad_in    = '0;
      filter_en = '0;
      tick(6);

      // Channel independence: pad 3 filtered (T=3), pad 5 bypass.
      filter_en = 8'h08;
      thresh    = 4'd3;
      pad_in    = 8'h28;
      tick(3);
      check("ind_c3_in",   32'(in_o), 32'h20);
      check("ind_c3_rise", 32'(rise), 32'h20);
      tick(3);
      check("ind_c6_in",   32'(in_o), 32'h28);
      check("ind_c6_rise", 32'(rise), 32'h08);
      pad_in = 8'h00;
      tick(3);
      check("ind_f3_in",   32'(in_o), 32'h08);
      check("ind_f3_fall", 32'(fall), 32'h20);
      tick(3);
      check("ind_f6_in",   32'(in_o), 32'h00);
      check("ind_f6_fall", 32'(fall), 32'h08);
      filter_en = '0;
      tick(4);

      // Inverted-low pad after reset produces a normal rise; invert change passes through.
      rst_n  = 1'b0;
      invert = 8'h01;
      tick(2);
      check("inv_rst_in",  32'(in_o), 32'h0);
      rst_n = 1'b1;
      tick(1);
      check("inv_rel_in",   32'(in_o), 32'h01);
      check("inv_rel_rise", 32'(rise), 32'h01);
      invert = 8'h00;
      tick(1);
      check("inv_chg_in",   32'(in_o), 32'h00);
      check("inv_chg_fall", 32'(fall), 32'h01);
      tick(4);

      // Output path and virtual open-drain.
      virt_od = 8'hFF;
      oe      = 8'hFF;
      out_d   = 8'h0F;
      check("out_pre_oe",  32'(pad_oe),  32'h00);
      tick(1);
      check("od_out_hi",   32'(pad_out), 32'h0F);
      check("od_oe_hi",    32'(pad_oe),  32'hF0);
      out_d = 8'h00;
      tick(1);
      check("od_out_lo",   32'(pad_out), 32'h00);
      check("od_oe_lo",    32'(pad_oe),  32'hFF);
      virt_od = 8'h00;
      invert  = 8'h03;
      out_d   = 8'h05;
      oe      = 8'h0C;
      tick(1);
      check("inv_out",     32'(pad_out), 32'h06);
      check("inv_oe",      32'(pad_oe),  32'h0C);
      virt_od = 8'h06;
      tick(1);
      check("od_mix_oe",   32'(pad_oe),  32'h08);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
